// File: rtl/core_config_pkg.sv
// Shared core configuration and divider-sequencer types.
//   XLEN             : integer register width
//   div_op_t         : funct3[1:0] encoding of the M-extension divide ops
//   div_seq_state_t  : divider sequencer controller states
//   SIGNED_MIN       : most negative XLEN-bit value (0x80..0)
//   ALL_ONES         : XLEN-bit all-ones value
package core_config_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        DRAIN,
        RESP
    } div_seq_state_t;

    localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES   = '1;

endpackage

// File: rtl/div_sequencer.sv
// Issue-side controller for the shared SRT divider.
// Accepts DIV/DIVU/REM/REMU requests, answers divide-by-zero, signed
// overflow and repeated-operand requests directly (latency 1), otherwise
// drives the divider start/done protocol and returns the tagged result.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_*                      : request handshake, op, operands, tag
//   flush                      : kill pending/in-flight operation
//   resp_*                     : tagged result handshake
//   busy                       : controller not idle
//   div_start/div_dividend/div_divisor/div_is_signed : divider issue side
//   div_quotient/div_remainder/div_done/div_by_zero  : divider result side
module div_sequencer #(
    parameter int unsigned XLEN     = core_config_pkg::XLEN,
    parameter int unsigned TAG_W    = 5,
    parameter bit          REUSE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy,
    output logic             div_start,
    output logic [XLEN-1:0]  div_dividend,
    output logic [XLEN-1:0]  div_divisor,
    output logic             div_is_signed,
    input  logic [XLEN-1:0]  div_quotient,
    input  logic [XLEN-1:0]  div_remainder,
    input  logic             div_done,
    input  logic             div_by_zero
);
    import core_config_pkg::*;

    localparam logic [XLEN-1:0] S_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES  = '1;

    div_seq_state_t state_q, state_d;

    logic [TAG_W-1:0] tag_q;
    logic             sel_rem_q;
    logic [XLEN-1:0]  resp_data_q;
    logic [XLEN-1:0]  dividend_q, divisor_q;
    logic             signed_q;

    logic             cache_valid;
    logic [XLEN-1:0]  cache_rs1, cache_rs2, cache_quo, cache_rem;
    logic             cache_signed;

    logic             accept, req_signed, req_rem;
    logic             is_zero, is_ovf, is_hit, fast;
    logic [XLEN-1:0]  fast_data;
    logic             done_live;

    // Zero-divisor handling is decided from the operands here.
    logic unused_div_by_zero;
    assign unused_div_by_zero = div_by_zero;

    assign req_signed = ~req_op[0];
    assign req_rem    = req_op[1];
    assign accept     = req_valid && req_ready;

    assign is_zero = (req_rs2 == '0);
    assign is_ovf  = req_signed && (req_rs1 == S_MIN) && (req_rs2 == ONES);
    assign is_hit  = REUSE_EN && cache_valid && (req_rs1 == cache_rs1) &&
                     (req_rs2 == cache_rs2) && (req_signed == cache_signed);
    assign fast    = is_zero || is_ovf || is_hit;

    // Priority: zero divisor, then overflow, then cached result.
    always_comb begin
        fast_data = '0;
        if (is_zero)
            fast_data = req_rem ? req_rs1 : ONES;
        else if (is_ovf)
            fast_data = req_rem ? '0 : S_MIN;
        else
            fast_data = req_rem ? cache_rem : cache_quo;
    end

    // A done in DRAIN still carries a valid result and refreshes the cache.
    assign done_live = div_done && ((state_q == WAIT) || (state_q == DRAIN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = fast ? RESP : START;
            START: state_d = flush ? IDLE : WAIT;
            WAIT: begin
                if (div_done)
                    state_d = flush ? IDLE : RESP;
                else if (flush)
                    state_d = DRAIN;
            end
            DRAIN: if (div_done) state_d = IDLE;
            RESP:  if (flush || resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = rst_n && (state_q == IDLE) && !flush;
        div_start  = (state_q == START) && !flush;
        resp_valid = (state_q == RESP) && !flush;
        busy       = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q        <= '0;
            sel_rem_q    <= 1'b0;
            resp_data_q  <= '0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            signed_q     <= 1'b0;
            cache_valid  <= 1'b0;
            cache_rs1    <= '0;
            cache_rs2    <= '0;
            cache_quo    <= '0;
            cache_rem    <= '0;
            cache_signed <= 1'b0;
        end else begin
            if (accept) begin
                tag_q     <= req_tag;
                sel_rem_q <= req_rem;
                if (fast) begin
                    resp_data_q <= fast_data;
                end else begin
                    // Held until the next slow accept, covering START..done+1.
                    dividend_q <= req_rs1;
                    divisor_q  <= req_rs2;
                    signed_q   <= req_signed;
                end
            end
            if (done_live) begin
                cache_valid  <= 1'b1;
                cache_rs1    <= dividend_q;
                cache_rs2    <= divisor_q;
                cache_signed <= signed_q;
                cache_quo    <= div_quotient;
                cache_rem    <= div_remainder;
            end
            if ((state_q == WAIT) && div_done)
                resp_data_q <= sel_rem_q ? div_remainder : div_quotient;
        end
    end

    assign resp_data     = resp_data_q;
    assign resp_tag      = tag_q;
    assign div_dividend  = dividend_q;
    assign div_divisor   = divisor_q;
    assign div_is_signed = signed_q;

endmodule
